popcount_neuron_seq: RTL

POPCOUNT_NEURON_SEQ -- requirements
Module: popcount_neuron_seq

---
 rtl/popcount_neuron_seq_pkg.sv | 16 +
 rtl/popcount_neuron_seq_core.sv | 16 +
 rtl/popcount_neuron_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/popcount_neuron_seq_pkg.sv
// Shared types and constants for the sequential popcount neuron.
package popcount_neuron_seq_pkg;

    localparam int unsigned CHUNK_W        = 23;
    localparam int unsigned PC_W           = 5;
    localparam int unsigned DEF_MAX_CHUNKS = 8;
    localparam int unsigned DEF_ACC_W      = 9;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_POS   = 2'd1,
        ST_NEG   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/popcount_neuron_seq_core.sv
// Combinational 23-bit population count, shared by both accumulate phases.
module popcount_neuron_seq_core
    import popcount_neuron_seq_pkg::*;
(
    input  logic [CHUNK_W-1:0] vec,
    output logic [PC_W-1:0]    count_c
);

    always_comb begin
        count_c = '0;
        for (int unsigned i = 0; i < CHUNK_W; i++) begin
            count_c = count_c + PC_W'(vec[i]);
        end
    end

endmodule

// File: rtl/popcount_neuron_seq.sv
// Binary-weight neuron: per chunk adds popcount(data&wpos), then subtracts
// popcount(data&wneg) through a single shared counter, and fires on sum >= threshold.
module popcount_neuron_seq
    import popcount_neuron_seq_pkg::*;
#(
    parameter int unsigned MAX_CHUNKS = DEF_MAX_CHUNKS,
    parameter int unsigned ACC_W      = DEF_ACC_W
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CHUNK_W-1:0]      in_data,
    input  logic [CHUNK_W-1:0]      in_wpos,
    input  logic [CHUNK_W-1:0]      in_wneg,
    input  logic                    in_last,
    input  logic signed [ACC_W-1:0] threshold,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    out_act,
    output logic                    out_trunc
);

    localparam int unsigned CNT_W = $clog2(MAX_CHUNKS + 1);

    state_t                  state_q, state_n;
    logic [CHUNK_W-1:0]      data_q, wpos_q, wneg_q;
    logic                    last_q, first_q;
    logic signed [ACC_W-1:0] thr_q, acc_q, acc_n;
    logic [CNT_W-1:0]        cnt_q, cnt_n;
    logic [CHUNK_W-1:0]      pc_vec_c;
    logic [PC_W-1:0]         pc_cnt_c;
    logic                    accept_c, out_hs_c, end_c, do_pos_c, do_neg_c;

    assign accept_c = in_valid && in_ready;
    assign out_hs_c = out_valid && out_ready;
    assign cnt_n    = cnt_q + CNT_W'(1);
    assign end_c    = last_q || (cnt_n == CNT_W'(MAX_CHUNKS));

    popcount_neuron_seq_core u_core (
        .vec     (pc_vec_c),
        .count_c (pc_cnt_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_READY;
        else     state_q <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_READY: if (accept_c) state_n = ST_POS;
            ST_POS:   state_n = ST_NEG;
            ST_NEG:   state_n = end_c ? ST_DONE : ST_READY;
            ST_DONE:  if (out_hs_c) state_n = ST_READY;
            default:  state_n = ST_READY;
        endcase
    end

    // Phase decode, shared-counter input mux and accumulator update
    always_comb begin
        do_pos_c = (state_q == ST_POS);
        do_neg_c = (state_q == ST_NEG);
        pc_vec_c = data_q & (do_pos_c ? wpos_q : wneg_q);
        acc_n    = acc_q;
        if (do_pos_c)      acc_n = acc_q + ACC_W'(pc_cnt_c);
        else if (do_neg_c) acc_n = acc_q - ACC_W'(pc_cnt_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            data_q    <= '0;
            wpos_q    <= '0;
            wneg_q    <= '0;
            last_q    <= 1'b0;
            first_q   <= 1'b1;
            thr_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_act   <= 1'b0;
            out_trunc <= 1'b0;
        end else begin
            in_ready <= (state_n == ST_READY);
            if (accept_c) begin
                data_q <= in_data;
                wpos_q <= in_wpos;
                wneg_q <= in_wneg;
                last_q <= in_last;
                if (first_q) begin
                    thr_q   <= threshold;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    first_q <= 1'b0;
                end
            end
            if (do_pos_c) acc_q <= acc_n;
            if (do_neg_c) begin
                acc_q <= acc_n;
                cnt_q <= cnt_n;
                // Result is frozen here and held through DONE
                if (end_c) begin
                    first_q   <= 1'b1;
                    out_valid <= 1'b1;
                    out_sum   <= acc_n;
                    out_act   <= (acc_n >= thr_q);
                    out_trunc <= !last_q;
                end
            end
            if (out_hs_c) out_valid <= 1'b0;
        end
    end

endmodule
